// File: rtl/instr_fetch_seq_pkg.sv
//------------------------------------------------------------------------------
// instr_fetch_seq_pkg : shared branch encodings, opcodes and fetch FSM states
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package instr_fetch_seq_pkg;

   // brhSel encodings from the control unit; bit 3 marks the branch class
   localparam logic [3:0] BR_B    = 4'b1000;
   localparam logic [3:0] BR_BR   = 4'b1001;
   localparam logic [3:0] BR_BLTZ = 4'b1010;
   localparam logic [3:0] BR_BZ   = 4'b1011;
   localparam logic [3:0] BR_BNZ  = 4'b1100;
   localparam logic [3:0] BR_BL   = 4'b1101;
   localparam logic [3:0] BR_BCY  = 4'b1110;
   localparam logic [3:0] BR_BNCY = 4'b1111;

   localparam int unsigned INSTR_W  = 32;
   localparam int unsigned OPCODE_W = 6;

   localparam logic [OPCODE_W-1:0] OP_ALU    = 6'h00;
   localparam logic [OPCODE_W-1:0] OP_BRANCH = 6'h04;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2
   } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/instr_fetch_seq_if.sv
//------------------------------------------------------------------------------
// instr_fetch_seq_if : instruction memory req/ready fetch bus
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface instr_fetch_seq_if #(
   parameter int unsigned ADDR_W = 32
) ();
   import instr_fetch_seq_pkg::*;

   logic               imem_req;
   logic [ADDR_W-1:0]  imem_addr;
   logic               imem_ready;
   logic [INSTR_W-1:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rdata
   );

endinterface

`default_nettype wire

// File: rtl/instr_fetch_seq_branch_resolve.sv
//------------------------------------------------------------------------------
// instr_fetch_seq_branch_resolve : branch condition and next-PC computation
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module instr_fetch_seq_branch_resolve
   import instr_fetch_seq_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input  wire logic [ADDR_W-1:0]  pc,
   input  wire logic [25:0]        ofs_field,
   input  wire logic [3:0]         brh_sel,
   input  wire logic               jump_addr,
   input  wire logic               lbl_sel,
   input  wire logic [INSTR_W-1:0] rs_data,
   input  wire logic               carry,
   output logic                    br_take,
   output logic [ADDR_W-1:0]       pc_link,
   output logic [ADDR_W-1:0]       next_pc
);

   logic [ADDR_W-1:0] ofs_ext;
   logic [ADDR_W-1:0] rel_target;
   logic [ADDR_W-1:0] raw_target;

   assign pc_link = pc + ADDR_W'(4);

   always_comb begin
      br_take = 1'b0;
      case (brh_sel)
         BR_B, BR_BR, BR_BL: br_take = 1'b1;
         BR_BLTZ:            br_take = rs_data[INSTR_W-1];
         BR_BZ:              br_take = (rs_data == '0);
         BR_BNZ:             br_take = (rs_data != '0);
         BR_BCY:             br_take = carry;
         BR_BNCY:            br_take = ~carry;
         default:            br_take = 1'b0;
      endcase
   end

   // Offset is a signed word count; short form uses only instr[20:0]
   always_comb begin
      if (lbl_sel) begin
         ofs_ext = {{(ADDR_W-21){ofs_field[20]}}, ofs_field[20:0]};
      end else begin
         ofs_ext = {{(ADDR_W-26){ofs_field[25]}}, ofs_field};
      end
      rel_target = pc_link + (ofs_ext << 2);
      raw_target = jump_addr ? ADDR_W'(rs_data) : rel_target;
      next_pc    = br_take ? {raw_target[ADDR_W-1:2], 2'b00} : pc_link;
   end

endmodule

`default_nettype wire

// File: rtl/instr_fetch_seq.sv
//------------------------------------------------------------------------------
// instr_fetch_seq : PC owner and fetch/exec sequencer, one instruction in flight
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module instr_fetch_seq
   import instr_fetch_seq_pkg::*;
#(
   parameter int unsigned       ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  wire logic                clk,
   input  wire logic                rst_n,
   input  wire logic                stall,
   instr_fetch_seq_if.master        imem,
   output logic [INSTR_W-1:0]       instr,
   output logic [OPCODE_W-1:0]      opcode,
   output logic                     instr_valid,
   output logic [ADDR_W-1:0]        pc,
   output logic [ADDR_W-1:0]        pc_link,
   input  wire logic [3:0]          brhSel,
   input  wire logic                jumpAddr,
   input  wire logic                lblSel,
   input  wire logic [INSTR_W-1:0]  rsData,
   input  wire logic                aluCarry,
   input  wire logic                aluCarryWe,
   output logic                     taken
);

   fetch_state_e         state_q, state_d;
   logic [ADDR_W-1:0]    pc_q, pc_d;
   logic [INSTR_W-1:0]   instr_q, instr_d;
   logic                 carry_q, carry_d;
   logic                 retire;
   logic                 br_take;
   logic [ADDR_W-1:0]    next_pc;

   instr_fetch_seq_branch_resolve #(
      .ADDR_W (ADDR_W)
   ) u_branch_resolve (
      .pc        (pc_q),
      .ofs_field (instr_q[25:0]),
      .brh_sel   (brhSel),
      .jump_addr (jumpAddr),
      .lbl_sel   (lblSel),
      .rs_data   (rsData),
      .carry     (carry_q),
      .br_take   (br_take),
      .pc_link   (pc_link),
      .next_pc   (next_pc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_BOOT;
         pc_q    <= RESET_PC;
         instr_q <= '0;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         carry_q <= carry_d;
      end
   end

   // Carry tracks the ALU independently of the FSM; branches see the pre-edge value
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      retire  = 1'b0;
      carry_d = aluCarryWe ? aluCarry : carry_q;
      case (state_q)
         ST_BOOT: begin
            state_d = ST_FETCH;
         end
         ST_FETCH: begin
            if (imem.imem_ready) begin
               instr_d = imem.imem_rdata;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (!stall) begin
               retire  = 1'b1;
               pc_d    = next_pc;
               state_d = ST_FETCH;
            end
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

   assign imem.imem_req  = (state_q == ST_FETCH);
   assign imem.imem_addr = pc_q;
   assign instr          = instr_q;
   assign opcode         = instr_q[INSTR_W-1:INSTR_W-OPCODE_W];
   assign instr_valid    = (state_q == ST_EXEC);
   assign pc             = pc_q;
   assign taken          = retire & br_take;

endmodule

`default_nettype wire
